alu_issue_arb: RTL and testbench

ALU_ISSUE_ARB -- requirements
Module: alu_issue_arb

---
 rtl/alu_issue_arb_if.sv | 30 +++
 rtl/alu_issue_arb.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_arb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_arb_if.sv
// Issue-arbiter bundle: per-slot set/kill requests in, ALU/multiplier grants out.
// master = the issue/commit logic driving requests; slave = the arbiter.
interface alu_issue_arb_if #(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5
);
    logic [NCOMMIT-1:0]  set_valid;
    logic [NCOMMIT-1:0]  set_mul;
    logic [NCOMMIT-1:0]  kill;
    logic [LNCOMMIT-1:0] commit_head;
    logic                alu_enable_0;
    logic                alu_enable_1;
    logic [LNCOMMIT-1:0] alu_addr_0;
    logic [LNCOMMIT-1:0] alu_addr_1;
    logic                mul_enable;
    logic [LNCOMMIT-1:0] mul_addr;
    logic                mul_busy;

    modport master (
        output set_valid, set_mul, kill, commit_head,
        input  alu_enable_0, alu_enable_1, alu_addr_0, alu_addr_1,
        input  mul_enable, mul_addr, mul_busy
    );

    modport slave (
        input  set_valid, set_mul, kill, commit_head,
        output alu_enable_0, alu_enable_1, alu_addr_0, alu_addr_1,
        output mul_enable, mul_addr, mul_busy
    );
endinterface

// File: rtl/alu_issue_arb.sv
// Age-ordered issue arbiter: two ALU ports plus one multi-cycle multiplier.
// Optional macro ALU_ARB_PERF_EN adds the issue_count performance counter port.
module alu_issue_arb #(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5,
    parameter int MUL_LAT  = 3
) (
    input  logic        clk,
    input  logic        reset,
`ifdef ALU_ARB_PERF_EN
    output logic [15:0] issue_count,
`endif
    alu_issue_arb_if.slave bus
);

    typedef enum logic {
        MUL_IDLE,
        MUL_BUSY
    } mul_state_t;

    logic [NCOMMIT-1:0]  alu_pend;
    logic [NCOMMIT-1:0]  mul_pend;
    logic [NCOMMIT-1:0]  alu_elig;
    logic [NCOMMIT-1:0]  mul_elig;
    logic [NCOMMIT-1:0]  new_entry;
    logic [NCOMMIT-1:0]  alu_grant_mask;
    logic [NCOMMIT-1:0]  mul_grant_mask;
    logic                alu_found0;
    logic                alu_found1;
    logic                mul_found;
    logic                mul_grant;
    logic [LNCOMMIT-1:0] alu_sel0;
    logic [LNCOMMIT-1:0] alu_sel1;
    logic [LNCOMMIT-1:0] mul_sel;
    logic [LNCOMMIT-1:0] idx;

    mul_state_t          mul_state;
    logic [2:0]          mul_count;

    logic                alu_en0_q;
    logic                alu_en1_q;
    logic [LNCOMMIT-1:0] alu_addr0_q;
    logic [LNCOMMIT-1:0] alu_addr1_q;
    logic                mul_en_q;
    logic [LNCOMMIT-1:0] mul_addr_q;

    assign alu_elig  = alu_pend & ~bus.kill;
    assign mul_elig  = mul_pend & ~bus.kill;
    // A slot already pending in either bitmap ignores a repeated set_valid/set_mul.
    assign new_entry = bus.set_valid & ~bus.kill & ~(alu_pend | mul_pend);
    assign mul_grant = mul_found && (mul_state == MUL_IDLE);

    // Walk slots oldest-first starting at commit_head; index wraps modulo NCOMMIT.
    always_comb begin
        alu_found0 = 1'b0;
        alu_found1 = 1'b0;
        mul_found  = 1'b0;
        alu_sel0   = '0;
        alu_sel1   = '0;
        mul_sel    = '0;
        idx        = '0;
        for (int unsigned i = 0; i < NCOMMIT; i++) begin
            idx = bus.commit_head + i[LNCOMMIT-1:0];
            if (alu_elig[idx]) begin
                if (!alu_found0) begin
                    alu_found0 = 1'b1;
                    alu_sel0   = idx;
                end else if (!alu_found1) begin
                    alu_found1 = 1'b1;
                    alu_sel1   = idx;
                end
            end
            if (mul_elig[idx] && !mul_found) begin
                mul_found = 1'b1;
                mul_sel   = idx;
            end
        end
    end

    always_comb begin
        alu_grant_mask = '0;
        mul_grant_mask = '0;
        if (alu_found0) alu_grant_mask[alu_sel0] = 1'b1;
        if (alu_found1) alu_grant_mask[alu_sel1] = 1'b1;
        if (mul_grant)  mul_grant_mask[mul_sel]  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_pend <= '0;
            mul_pend <= '0;
        end else begin
            alu_pend <= (alu_pend & ~bus.kill & ~alu_grant_mask) | (new_entry & ~bus.set_mul);
            mul_pend <= (mul_pend & ~bus.kill & ~mul_grant_mask) | (new_entry & bus.set_mul);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_en0_q   <= 1'b0;
            alu_en1_q   <= 1'b0;
            alu_addr0_q <= '0;
            alu_addr1_q <= '0;
        end else begin
            alu_en0_q   <= alu_found0;
            alu_en1_q   <= alu_found1;
            alu_addr0_q <= alu_found0 ? alu_sel0 : '0;
            alu_addr1_q <= alu_found1 ? alu_sel1 : '0;
        end
    end

    // Multiplier occupancy: count holds remaining busy cycles after the grant cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_state  <= MUL_IDLE;
            mul_count  <= '0;
            mul_en_q   <= 1'b0;
            mul_addr_q <= '0;
        end else begin
            case (mul_state)
                MUL_IDLE: begin
                    if (mul_found) begin
                        mul_en_q   <= 1'b1;
                        mul_addr_q <= mul_sel;
                        mul_count  <= 3'(MUL_LAT - 1);
                        mul_state  <= (MUL_LAT > 1) ? MUL_BUSY : MUL_IDLE;
                    end else begin
                        mul_en_q   <= 1'b0;
                        mul_addr_q <= '0;
                    end
                end
                MUL_BUSY: begin
                    mul_en_q   <= 1'b0;
                    mul_addr_q <= '0;
                    mul_count  <= mul_count - 3'd1;
                    if (mul_count == 3'd1) mul_state <= MUL_IDLE;
                end
                default: begin
                    mul_state <= MUL_IDLE;
                    mul_count <= '0;
                end
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_count <= '0;
        end else begin
            issue_count <= issue_count + 16'(alu_found0) + 16'(alu_found1) + 16'(mul_grant);
        end
    end
`endif

    assign bus.alu_enable_0 = alu_en0_q;
    assign bus.alu_enable_1 = alu_en1_q;
    assign bus.alu_addr_0   = alu_addr0_q;
    assign bus.alu_addr_1   = alu_addr1_q;
    assign bus.mul_enable   = mul_en_q;
    assign bus.mul_addr     = mul_addr_q;
    assign bus.mul_busy     = (mul_state == MUL_BUSY);

endmodule

// File: tb/tb_alu_issue_arb.sv
// Directed bench for alu_issue_arb (NCOMMIT=32, MUL_LAT=3); define ALU_ARB_PERF_EN
// to also exercise the issue_count counter.
module tb_alu_issue_arb;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] issue_count;
`endif

    alu_issue_arb_if #(.NCOMMIT(32), .LNCOMMIT(5)) bus ();

    alu_issue_arb #(.NCOMMIT(32), .LNCOMMIT(5), .MUL_LAT(3)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef ALU_ARB_PERF_EN
        .issue_count (issue_count),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] v, input logic [31:0] m, input logic [31:0] k);
        bus.set_valid = v;
        bus.set_mul   = m;
        bus.kill      = k;
    endtask

    initial begin
        drive('0, '0, '0);
        bus.commit_head = 5'd0;
        tick();
        tick();
        check("rst_en0", 32'(bus.alu_enable_0), 0);
        check("rst_en1", 32'(bus.alu_enable_1), 0);
        check("rst_mul_en", 32'(bus.mul_enable), 0);
        check("rst_busy", 32'(bus.mul_busy), 0);
        check("rst_addr0", 32'(bus.alu_addr_0), 0);
        check("rst_mul_addr", 32'(bus.mul_addr), 0);
`ifdef ALU_ARB_PERF_EN
        check("rst_count", 32'(issue_count), 0);
`endif
        reset = 1'b0;
        tick();

        // Wrap-around priority from head 30: slots 1, 29, 31
        bus.commit_head = 5'd30;
        drive(32'hA000_0002, '0, '0);
        tick();
        drive('0, '0, '0);
        check("wrap_lat_en0", 32'(bus.alu_enable_0), 0);
        tick();
        check("wrap_en0", 32'(bus.alu_enable_0), 1);
        check("wrap_addr0", 32'(bus.alu_addr_0), 31);
        check("wrap_en1", 32'(bus.alu_enable_1), 1);
        check("wrap_addr1", 32'(bus.alu_addr_1), 1);
        tick();
        check("wrap2_en0", 32'(bus.alu_enable_0), 1);
        check("wrap2_addr0", 32'(bus.alu_addr_0), 29);
        check("wrap2_en1", 32'(bus.alu_enable_1), 0);
        check("wrap2_addr1", 32'(bus.alu_addr_1), 0);
        tick();
        check("wrap3_en0", 32'(bus.alu_enable_0), 0);
        check("wrap3_addr0", 32'(bus.alu_addr_0), 0);

        // Head 0: slots 0, 2, 31
        bus.commit_head = 5'd0;
        drive(32'h8000_0005, '0, '0);
        tick();
        drive('0, '0, '0);
        tick();
        check("h0_addr0", 32'(bus.alu_addr_0), 0);
        check("h0_addr1", 32'(bus.alu_addr_1), 2);
        tick();
        check("h0b_addr0", 32'(bus.alu_addr_0), 31);
        check("h0b_en1", 32'(bus.alu_enable_1), 0);
        tick();

        // Multiplier: slots 4 and 5, kill on 4 while busy must not abort
        drive(32'h30, 32'h30, '0);
        tick();
        drive('0, '0, '0);
        check("mul_lat_en", 32'(bus.mul_enable), 0);
        tick();
        check("mul1_en", 32'(bus.mul_enable), 1);
        check("mul1_addr", 32'(bus.mul_addr), 4);
        check("mul1_busy", 32'(bus.mul_busy), 1);
        check("mul1_alu_en0", 32'(bus.alu_enable_0), 0);
        bus.kill = 32'h10;
        tick();
        bus.kill = '0;
        check("mul2_en", 32'(bus.mul_enable), 0);
        check("mul2_addr", 32'(bus.mul_addr), 0);
        check("mul2_busy", 32'(bus.mul_busy), 1);
        tick();
        check("mul3_busy", 32'(bus.mul_busy), 0);
        check("mul3_en", 32'(bus.mul_enable), 0);
        tick();
        check("mul4_en", 32'(bus.mul_enable), 1);
        check("mul4_addr", 32'(bus.mul_addr), 5);
        tick();
        tick();
        check("mul_drain_busy", 32'(bus.mul_busy), 0);
        tick();

        // Set and kill slot 7 together: never granted
        drive(32'h80, '0, 32'h80);
        tick();
        drive('0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("kill7_en0", 32'(bus.alu_enable_0), 0);
        end

        // Slot 9 pending, killed during its selection cycle
        drive(32'h200, '0, '0);
        tick();
        drive('0, '0, 32'h200);
        tick();
        bus.kill = '0;
        check("kill9_en0", 32'(bus.alu_enable_0), 0);
        check("kill9_pend", 32'(dut.alu_pend[9]), 0);
        tick();
        check("kill9_en0_late", 32'(bus.alu_enable_0), 0);

        // Repeat set_valid with set_mul on a pending ALU slot 12 is ignored
        drive(32'h1000, '0, '0);
        tick();
        drive(32'h1000, 32'h1000, '0);
        tick();
        drive('0, '0, '0);
        check("rep_en0", 32'(bus.alu_enable_0), 1);
        check("rep_addr0", 32'(bus.alu_addr_0), 12);
        check("rep_mul_en", 32'(bus.mul_enable), 0);
        tick();
        check("rep_mul_en2", 32'(bus.mul_enable), 0);
        check("rep_en0_2", 32'(bus.alu_enable_0), 0);
        tick();

        // Asynchronous reset mid-multiply (count=1) with an ALU grant active
        drive(32'h4, 32'h4, '0);
        tick();
        drive(32'h400, '0, '0);
        tick();
        drive('0, '0, '0);
        check("mid_mul_en", 32'(bus.mul_enable), 1);
        check("mid_mul_addr", 32'(bus.mul_addr), 2);
        tick();
        check("mid_en0", 32'(bus.alu_enable_0), 1);
        check("mid_addr0", 32'(bus.alu_addr_0), 10);
        check("mid_busy", 32'(bus.mul_busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(bus.mul_busy), 0);
        check("arst_en0", 32'(bus.alu_enable_0), 0);
        check("arst_addr0", 32'(bus.alu_addr_0), 0);
        check("arst_mul_en", 32'(bus.mul_enable), 0);
        tick();
        reset = 1'b0;
        drive(32'h8, '0, '0);
        tick();
        drive('0, '0, '0);
        check("post_rst_lat", 32'(bus.alu_enable_0), 0);
        tick();
        check("post_rst_en0", 32'(bus.alu_enable_0), 1);
        check("post_rst_addr0", 32'(bus.alu_addr_0), 3);
        tick();

`ifdef ALU_ARB_PERF_EN
        reset = 1'b1;
        #1;
        check("perf_clr", 32'(issue_count), 0);
        tick();
        reset = 1'b0;
        drive(32'hF, 32'h8, '0);
        tick();
        drive('0, '0, '0);
        for (int i = 0; i < 6; i++) tick();
        check("perf_count", 32'(issue_count), 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
